// File: rtl/glyph_frame_sequencer_if.sv
// Bus between the frame sequencer and its surroundings.
//
// Signals (direction as seen by the sequencer):
//   vsync      in   vertical sync from the sync generator
//   mode_req   in   requested video mode
//   pal_req    in   requested palette id
//   pause      in   level, freezes frame advance
//   step       in   one-cycle pulse, single-frame advance while paused
//   gen_reset  out  synchronous reset to the sync generator
//   mode       out  applied video mode
//   pal        out  applied palette id
//   frame      out  animation frame counter
//   drop_en    out  high during the initial drop pass
//   frame_tick out  one-cycle pulse per accepted frame boundary
//   state_dbg  out  current sequencer state (0 = SETTLE, 1 = RUN)
//
// Handshake: there is no backpressure. frame_tick acts as the valid strobe
// for a frame boundary: in the cycle it is high, frame/pal/drop_en already
// hold the values for the new frame, and no consumer can stall it.
interface glyph_frame_sequencer_if #(
    parameter int FRAME_W = 10
);
    logic               vsync;
    logic [1:0]         mode_req;
    logic [1:0]         pal_req;
    logic               pause;
    logic               step;
    logic               gen_reset;
    logic [1:0]         mode;
    logic [1:0]         pal;
    logic [FRAME_W-1:0] frame;
    logic               drop_en;
    logic               frame_tick;
    logic               state_dbg;

    modport master (
        output vsync, mode_req, pal_req, pause, step,
        input  gen_reset, mode, pal, frame, drop_en, frame_tick, state_dbg
    );

    modport slave (
        input  vsync, mode_req, pal_req, pause, step,
        output gen_reset, mode, pal, frame, drop_en, frame_tick, state_dbg
    );
endinterface

// File: rtl/glyph_frame_sequencer.sv
// Frame-level controller for the glyph-rain pipeline.
//
// Detects the vsync rising edge, advances the animation frame counter
// (with pause / single-step), owns the one-shot initial drop pass, and
// applies mode and palette changes only at frame boundaries. After reset
// and after every mode change the sync generator is held in reset for
// SETTLE_CYCLES cycles.
//
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high
//   bus    glyph_frame_sequencer_if.slave (see interface file)
module glyph_frame_sequencer #(
    parameter int FRAME_W       = 10,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    glyph_frame_sequencer_if.slave        bus
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gen_reset_q, gen_reset_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         pal_q, pal_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               drop_en_q, drop_en_d;
    logic               frame_tick_q, frame_tick_d;
    logic               step_pending_q, step_pending_d;
    logic               vs_q, vs_d;

    logic               vs_edge;
    logic               advance;

    assign vs_edge = bus.vsync & ~vs_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        gen_reset_d    = gen_reset_q;
        mode_d         = mode_q;
        pal_d          = pal_q;
        frame_d        = frame_q;
        drop_en_d      = drop_en_q;
        frame_tick_d   = 1'b0;
        step_pending_d = step_pending_q;
        vs_d           = bus.vsync;
        advance        = 1'b0;

        case (state_q)
            ST_SETTLE: begin
                // vsync edges are dropped here; a step still counts as a
                // pending request because no boundary is being taken.
                gen_reset_d = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (bus.step) begin
                    step_pending_d = 1'b1;
                end
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    gen_reset_d = 1'b0;
                end
            end
            default: begin
                gen_reset_d = 1'b0;
                if (vs_edge) begin
                    if (bus.mode_req != mode_q) begin
                        // Reconfig: restart the animation and re-settle.
                        mode_d         = bus.mode_req;
                        frame_d        = '0;
                        drop_en_d      = 1'b1;
                        step_pending_d = 1'b0;
                        state_d        = ST_SETTLE;
                        cnt_d          = '0;
                        gen_reset_d    = 1'b1;
                    end else begin
                        frame_tick_d   = 1'b1;
                        pal_d          = bus.pal_req;
                        // A step arriving on the boundary cycle itself counts.
                        advance        = ~bus.pause | step_pending_q | bus.step;
                        step_pending_d = 1'b0;
                        if (advance) begin
                            frame_d = frame_q + 1'b1;
                            if (&frame_q) begin
                                drop_en_d = 1'b0;
                            end
                        end
                    end
                end else if (bus.step) begin
                    step_pending_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_SETTLE;
            cnt_q          <= '0;
            gen_reset_q    <= 1'b1;
            mode_q         <= 2'd0;
            pal_q          <= 2'd0;
            frame_q        <= '0;
            drop_en_q      <= 1'b1;
            frame_tick_q   <= 1'b0;
            step_pending_q <= 1'b0;
            // Reset high so a vsync already high at release is not an edge.
            vs_q           <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gen_reset_q    <= gen_reset_d;
            mode_q         <= mode_d;
            pal_q          <= pal_d;
            frame_q        <= frame_d;
            drop_en_q      <= drop_en_d;
            frame_tick_q   <= frame_tick_d;
            step_pending_q <= step_pending_d;
            vs_q           <= vs_d;
        end
    end

    assign bus.gen_reset  = gen_reset_q;
    assign bus.mode       = mode_q;
    assign bus.pal        = pal_q;
    assign bus.frame      = frame_q;
    assign bus.drop_en    = drop_en_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_glyph_frame_sequencer.sv
module tb_glyph_frame_sequencer;
    localparam int FRAME_W = 10;
    localparam int W       = FRAME_W + 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [W-1:0] exp_q[$];
    logic [FRAME_W-1:0] exp_frame;
    logic exp_drop;

    glyph_frame_sequencer_if #(.FRAME_W(FRAME_W)) bus ();

    glyph_frame_sequencer #(.FRAME_W(FRAME_W), .SETTLE_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [FRAME_W-1:0] f, input logic [1:0] p, input logic d);
        exp_q.push_back({f, p, d});
    endtask

    task automatic vs_pulse();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        tick();
        tick();
    endtask

    // Normal boundary with pause=0: bench model of the expected frame.
    task automatic run_pulse(input logic [1:0] p);
        if (exp_frame == {FRAME_W{1'b1}}) exp_drop = 1'b0;
        exp_frame = exp_frame + 1'b1;
        push_exp(exp_frame, p, exp_drop);
        vs_pulse();
    endtask

    task automatic count_gen_reset(input int req, input string name, input bit toggle);
        int n;
        n = 0;
        while (bus.gen_reset === 1'b1 && n < 40) begin
            n++;
            if (toggle) bus.vsync = (n % 3 == 1);
            tick();
        end
        bus.vsync = 1'b0;
        chk(name, n, req);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gen_reset"}, bus.gen_reset, 1);
        chk({tag, "_mode"}, bus.mode, 0);
        chk({tag, "_pal"}, bus.pal, 0);
        chk({tag, "_frame"}, bus.frame, 0);
        chk({tag, "_drop_en"}, bus.drop_en, 1);
        chk({tag, "_frame_tick"}, bus.frame_tick, 0);
        chk({tag, "_state"}, bus.state_dbg, 0);
    endtask

    // scoreboard monitor: pops one expectation per frame_tick
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.frame_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick actual=1 required=0 frame=%0d", bus.frame);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_frame", bus.frame, e[W-1:3]);
                    chk("tick_pal", bus.pal, e[2:1]);
                    chk("tick_drop_en", bus.drop_en, e[0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.vsync = 1'b0;
        bus.mode_req = 2'd0;
        bus.pal_req = 2'd0;
        bus.pause = 1'b0;
        bus.step = 1'b0;
        tick(); tick(); tick();
        chk_reset_vals("rst");

        reset = 1'b0;
        count_gen_reset(16, "settle_after_reset", 1'b0);
        chk("run_state", bus.state_dbg, 1);
        chk("run_frame0", bus.frame, 0);
        chk("run_drop0", bus.drop_en, 1);
        tick(); tick(); tick();

        // 1024 frames: wrap clears drop_en
        exp_frame = '0;
        exp_drop = 1'b1;
        for (int i = 0; i < 1024; i++) run_pulse(2'd0);
        chk("wrap_frame", bus.frame, 0);
        chk("wrap_drop_en", bus.drop_en, 0);
        for (int i = 0; i < 50; i++) run_pulse(2'd0);
        chk("post_wrap_frame", bus.frame, 50);
        chk("post_wrap_drop_en", bus.drop_en, 0);

        // pause with one step between edges 2 and 3
        bus.pause = 1'b1;
        push_exp(10'd50, 2'd0, 1'b0); vs_pulse();
        push_exp(10'd50, 2'd0, 1'b0); vs_pulse();
        bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
        push_exp(10'd51, 2'd0, 1'b0); vs_pulse();
        push_exp(10'd51, 2'd0, 1'b0); vs_pulse();
        push_exp(10'd51, 2'd0, 1'b0); vs_pulse();

        // step coincident with the edge while paused
        push_exp(10'd52, 2'd0, 1'b0);
        bus.vsync = 1'b1; bus.step = 1'b1;
        tick();
        bus.vsync = 1'b0; bus.step = 1'b0;
        tick(); tick();
        push_exp(10'd52, 2'd0, 1'b0); vs_pulse();
        bus.pause = 1'b0;

        // run on to frame 37 (wraps again, drop_en stays 0)
        exp_frame = 10'd52;
        exp_drop = 1'b0;
        for (int i = 0; i < 1009; i++) run_pulse(2'd0);
        chk("at37_frame", bus.frame, 37);
        chk("at37_drop_en", bus.drop_en, 0);

        // mode change requested mid-frame, applied at next edge
        bus.mode_req = 2'd2;
        tick(); tick();
        chk("midframe_mode", bus.mode, 0);
        chk("midframe_frame", bus.frame, 37);
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        chk("reconf_mode", bus.mode, 2);
        chk("reconf_frame", bus.frame, 0);
        chk("reconf_drop_en", bus.drop_en, 1);
        chk("reconf_no_tick", bus.frame_tick, 0);
        chk("reconf_state", bus.state_dbg, 0);
        // vsync toggles inside the window, including the final SETTLE cycle
        count_gen_reset(16, "settle_after_reconf", 1'b1);
        tick(); tick(); tick();

        // palette applied only at boundaries
        bus.pal_req = 2'd1;
        push_exp(10'd1, 2'd1, 1'b1); vs_pulse();
        bus.pal_req = 2'd3;
        tick();
        chk("midframe_pal", bus.pal, 1);
        push_exp(10'd2, 2'd3, 1'b1); vs_pulse();
        chk("pal_applied", bus.pal, 3);

        // reset in the middle of a SETTLE window
        bus.mode_req = 2'd1;
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        chk("reconf2_gen_reset", bus.gen_reset, 1);
        chk("reconf2_mode", bus.mode, 1);
        tick(); tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk_reset_vals("midsettle_rst");
        bus.mode_req = 2'd0;
        reset = 1'b0;
        count_gen_reset(16, "settle_after_midrst", 1'b0);
        push_exp(10'd1, 2'd3, 1'b1); vs_pulse();

        tick(); tick(); tick(); tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/glyph_frame_sequencer.md
# glyph_frame_sequencer

Frame-level controller for the VGA glyph-rain pipeline. It sits between the pins/config inputs and the sync generator plus glyph datapath, all in the pixel clock domain. It detects the vertical-sync rising edge and advances the animation frame counter, with pause and single-step. It owns the one-shot "initial rain drop" phase and applies mode and palette changes only at frame boundaries, holding the sync generator in reset for a settle window after each mode change.

## Interface
Parameters:
- FRAME_W, 10, frame counter width
- SETTLE_CYCLES, 16, cycles `gen_reset` stays high after reset or a mode change (minimum 1)

Ports:
- clk  in  1  pixel clock, single clock domain
- reset  in  1  synchronous, active-high reset
- vsync  in  1  vertical sync from the sync generator; the rising edge is the frame boundary
- mode_req  in  2  requested video mode
- pal_req  in  2  requested palette id
- pause  in  1  level; freezes `frame` advance
- step  in  1  one-cycle pulse; requests a single-frame advance while paused
- gen_reset  out  1  synchronous reset to the sync generator
- mode  out  2  applied video mode, to the sync generator
- pal  out  2  applied palette id, to the palette ROM
- frame  out  FRAME_W  animation frame counter
- drop_en  out  1  high during the initial drop pass
- frame_tick  out  1  one-cycle pulse per accepted frame boundary

## Operation
- Edge detect: register `vs_q <= vsync`. The edge is `vsync & ~vs_q`. `vs_q` resets to 1, so there is no spurious edge out of reset.
- States: SETTLE, RUN. The SETTLE counter is ceil(log2(SETTLE_CYCLES+1)) bits wide.
- Reset values:
  - state = SETTLE, counter = 0
  - gen_reset = 1, mode = 0, pal = 0
  - frame = 0, drop_en = 1, frame_tick = 0, step_pending = 0
- SETTLE:
  - gen_reset = 1.
  - The counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, go to RUN, clear the counter, and drive gen_reset = 0 from the next cycle.
  - vsync edges are ignored. frame_tick = 0. frame, pal and drop_en hold.
- RUN, on a vsync edge with mode_req != mode (reconfig):
  - mode <= mode_req, frame <= 0, drop_en <= 1, step_pending <= 0.
  - Enter SETTLE. No frame_tick. pal is unchanged.
- RUN, on a vsync edge with mode_req == mode (normal boundary):
  - frame_tick <= 1 and pal <= pal_req.
  - frame advances (+1, modulo 2^FRAME_W) if pause == 0, or if pause == 1 and (step_pending | step).
  - step_pending <= 0 on every normal boundary; a step while not paused is absorbed.
  - If the advance wraps frame from all-ones to 0, drop_en <= 0. It stays 0 until reset or reconfig.
- Step capture: `step` sets step_pending in any cycle without a boundary. In RUN, step on the boundary cycle counts as pending for that boundary.
- frame_tick is 0 in every cycle other than the one following an accepted boundary.
- mode_req and pal_req are not sampled between boundaries; glitches on them are invisible.

## Timing
- All outputs are registered.
- A vsync rising edge sampled at clk edge k updates frame, pal, mode, drop_en and frame_tick after edge k; values are visible in cycle k+1 (1-cycle latency).
- gen_reset is high for exactly SETTLE_CYCLES cycles after reset deassertion, and for exactly SETTLE_CYCLES cycles after a reconfig boundary.
- Reset mid-SETTLE or mid-RUN returns every output to its reset value on the next clk edge.
- A vsync edge in the final SETTLE cycle is ignored; no edges are buffered.
- Back-to-back boundaries cannot occur; the design relies on at least 2 clk cycles between vsync edges.

## Test plan
- Reset release, SETTLE_CYCLES=16, mode_req=0 -> gen_reset high for 16 cycles, then 0. frame=0, drop_en=1, no frame_tick before the first vsync edge.
- 1024 vsync pulses, pause=0 -> 1024 frame_tick pulses, frame returns to 0. drop_en falls in the cycle after the 1024th edge and stays 0 for a further 50 frames.
- pause=1 for 5 edges, with one step pulse between edges 2 and 3 -> frame increments only at edge 3. frame_tick still pulses 5 times.
- Simultaneous step and vsync edge while paused -> frame increments by exactly 1 at that edge; the next paused edge gives no increment.
- At frame=37 with drop_en=0, set mode_req 0->2 mid-frame -> no change until the next edge. At that edge: mode=2, frame=0, drop_en=1, no tick, gen_reset high for 16 cycles; edges during that window produce no tick.
- Change pal_req 1->3 mid-frame; assert reset in the middle of the SETTLE window -> pal stays 1 until the edge, then 3. On reset, all outputs return to reset values in the next cycle and SETTLE restarts from count 0.
